// File: rtl/xsvi_timing_pkg.sv
// rtl/xsvi_timing_pkg.sv - shared timing defaults, counter widths and pipeline types for the XSVI video generator
// Purpose: single home for 800x600@60 timing defaults, image window size, background colour,
//          counter widths and the stage-1 flag bundle used by xsvi_video_gen.
// Ports:   none (package).
package xsvi_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_H_TOTAL = 1056;
    localparam int DEF_H_SYNC  = 128;
    localparam int DEF_H_BACK  = 88;
    localparam int DEF_H_FRONT = 40;
    localparam int DEF_V_TOTAL = 628;
    localparam int DEF_V_SYNC  = 4;
    localparam int DEF_V_BACK  = 23;
    localparam int DEF_V_FRONT = 1;
    localparam int DEF_IMG_W   = 256;
    localparam int DEF_IMG_H   = 256;
    localparam logic [23:0] DEF_BG_COLOR = 24'h000000;

    typedef logic [X_W-1:0] cnt_x_t;
    typedef logic [Y_W-1:0] cnt_y_t;

    // Decode flags captured in stage 1 alongside rom_addr.
    typedef struct packed {
        logic valid;
        logic h_sync;
        logic v_sync;
        logic active;
        logic in_img;
        logic first;
    } stage1_t;

endpackage

// File: rtl/xsvi_pix_counter.sv
// rtl/xsvi_pix_counter.sv - horizontal/vertical pixel position counter with wrap and enable clear
// Purpose: cnt_x runs 0..H_TOTAL-1, cnt_y steps on each cnt_x wrap and runs 0..V_TOTAL-1.
//          Reset or en=0 parks both counters at 0 so a re-enable starts a clean frame.
// Ports:   i_clk    - pixel clock
//          i_rst    - synchronous active-high reset (priority over i_en)
//          i_en     - run enable
//          o_cnt_x  - horizontal position
//          o_cnt_y  - vertical position
module xsvi_pix_counter
    import xsvi_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_en,
    output cnt_x_t o_cnt_x,
    output cnt_y_t o_cnt_y
);

    cnt_x_t r_cnt_x;
    cnt_y_t r_cnt_y;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt_x <= '0;
            r_cnt_y <= '0;
        end else if (r_cnt_x == cnt_x_t'(H_TOTAL - 1)) begin
            r_cnt_x <= '0;
            r_cnt_y <= (r_cnt_y == cnt_y_t'(V_TOTAL - 1)) ? '0 : r_cnt_y + cnt_y_t'(1);
        end else begin
            r_cnt_x <= r_cnt_x + cnt_x_t'(1);
        end
    end

    assign o_cnt_x = r_cnt_x;
    assign o_cnt_y = r_cnt_y;

endmodule

// File: rtl/xsvi_video_gen.sv
// rtl/xsvi_video_gen.sv - XSVI timing generator streaming an image window from memory
// Purpose: decodes sync/active/image-window from the pixel counters, fetches pixels from an
//          image memory and drives XSVI video with a fixed 2-clock counter-to-output latency.
// Ports:   xsvi_pix_clk      - pixel clock
//          Bus2IP_Reset      - synchronous active-high reset
//          en                - run enable (encoder init done)
//          rom_addr          - image memory read address (registered, 0 outside the window)
//          rom_data          - image memory data, RGB 8:8:8, sampled one clock after rom_addr
//          xsvi_h_sync       - horizontal sync, active-low
//          xsvi_v_sync       - vertical sync, active-low
//          xsvi_video_active - data enable
//          xsvi_video_data   - pixel RGB
//          frame_start       - one-cycle pulse on the first pixel of each frame
module xsvi_video_gen
    import xsvi_timing_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int IMG_H   = DEF_IMG_H,
    parameter logic [23:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic        xsvi_pix_clk,
    input  logic        Bus2IP_Reset,
    input  logic        en,
    output logic [15:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        xsvi_h_sync,
    output logic        xsvi_v_sync,
    output logic        xsvi_video_active,
    output logic [23:0] xsvi_video_data,
    output logic        frame_start
);

    localparam int H_ACT_S = H_SYNC + H_BACK;
    localparam int H_ACT_E = H_TOTAL - H_FRONT;
    localparam int V_ACT_S = V_SYNC + V_BACK;
    localparam int V_ACT_E = V_TOTAL - V_FRONT;
    localparam logic [15:0] IMG_W16 = 16'(IMG_W);

    cnt_x_t      w_cnt_x;
    cnt_y_t      w_cnt_y;
    cnt_x_t      w_ax;
    cnt_y_t      w_ay;
    logic        w_active;
    logic        w_in_img;
    logic [15:0] w_addr;

    stage1_t     r_s1;
    logic [15:0] r_rom_addr;
    logic        r_h_sync;
    logic        r_v_sync;
    logic        r_active;
    logic [23:0] r_data;
    logic        r_frame_start;

    xsvi_pix_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_pix_counter (
        .i_clk   (xsvi_pix_clk),
        .i_rst   (Bus2IP_Reset),
        .i_en    (en),
        .o_cnt_x (w_cnt_x),
        .o_cnt_y (w_cnt_y)
    );

    assign w_active = (w_cnt_x >= cnt_x_t'(H_ACT_S)) && (w_cnt_x < cnt_x_t'(H_ACT_E)) &&
                      (w_cnt_y >= cnt_y_t'(V_ACT_S)) && (w_cnt_y < cnt_y_t'(V_ACT_E));
    // ax/ay wrap to large values before the active start; w_active masks that case.
    assign w_ax     = w_cnt_x - cnt_x_t'(H_ACT_S);
    assign w_ay     = w_cnt_y - cnt_y_t'(V_ACT_S);
    assign w_in_img = w_active && (w_ax < cnt_x_t'(IMG_W)) && (w_ay < cnt_y_t'(IMG_H));
    assign w_addr   = 16'(w_ax) + IMG_W16 * 16'(w_ay);

    // Stage 1: decode flags and memory address from the counters.
    always_ff @(posedge xsvi_pix_clk) begin
        if (Bus2IP_Reset) begin
            r_s1       <= '0;
            r_rom_addr <= '0;
        end else begin
            r_s1.valid  <= en;
            r_s1.h_sync <= (w_cnt_x >= cnt_x_t'(H_SYNC));
            r_s1.v_sync <= (w_cnt_y >= cnt_y_t'(V_SYNC));
            r_s1.active <= w_active;
            r_s1.in_img <= w_in_img;
            r_s1.first  <= (w_cnt_x == '0) && (w_cnt_y == '0);
            r_rom_addr  <= w_in_img ? w_addr : '0;
        end
    end

    // Stage 2: outputs; rom_data for the stage-1 address arrives in time for this edge.
    always_ff @(posedge xsvi_pix_clk) begin
        if (Bus2IP_Reset || !r_s1.valid) begin
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_active      <= 1'b0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync      <= r_s1.h_sync;
            r_v_sync      <= r_s1.v_sync;
            r_active      <= r_s1.active;
            r_data        <= r_s1.in_img ? rom_data : (r_s1.active ? BG_COLOR : 24'h000000);
            r_frame_start <= r_s1.first;
        end
    end

    assign rom_addr          = r_rom_addr;
    assign xsvi_h_sync       = r_h_sync;
    assign xsvi_v_sync       = r_v_sync;
    assign xsvi_video_active = r_active;
    assign xsvi_video_data   = r_data;
    assign frame_start       = r_frame_start;

endmodule
